mm_burst_bridge: RTL and testbench

Converts the cache's line-granular main-memory requests (256-bit fill/evict, single-cycle command strobes) into 8-beat 32-bit Avalon-MM bursts toward external memory. It sits directly downstream of the cache's mm_* port. Reads are gathered into a 256-bit line and returned with a one-cycle valid pulse. Write bursts are serialized from a captured eviction line.

---
 rtl/mm_burst_bridge_pkg.sv | 24 ++
 rtl/mm_burst_bridge_gather.sv | 42 ++++
 rtl/mm_burst_bridge.sv | 193 +++++++++++++++++++
 tb/tb_mm_burst_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_burst_bridge_pkg.sv
// Shared definitions for the line-to-burst memory bridge.
// Holds the FSM state encodings, the default line and beat geometry, and the line-alignment helper.
// Contains no logic, so it adds no latency and applies no backpressure.
package mm_burst_bridge_pkg;

    localparam int DEF_LINE_BITS = 256;
    localparam int DEF_BEAT_BITS = 32;
    localparam int DEF_BEATS     = DEF_LINE_BITS / DEF_BEAT_BITS;
    localparam int LINE_BYTES    = DEF_LINE_BITS / 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_BURST = 3'd1,
        ST_RD_CMD   = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    // Clear the byte-within-line offset so every burst starts on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] a);
        return a & ~32'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/mm_burst_bridge_gather.sv
// Beat-indexed assembly register that builds the fill line presented on mm_rd.
// Latency: a beat written with we appears in line one cycle later.
// Backpressure: none; every we is taken, and clr takes priority over we.
module line_gather
    import mm_burst_bridge_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int BEAT_BITS = DEF_BEAT_BITS,
    parameter int BEATS     = DEF_BEATS
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 we,
    input  logic [3:0]           idx,
    input  logic [BEAT_BITS-1:0] din,
    output logic [LINE_BITS-1:0] line
);

    logic [LINE_BITS-1:0] line_d, line_q;

    // Drop the incoming beat into slice idx; slices that are not written keep the previous line.
    always_comb begin
        line_d = line_q;
        if (clr) begin
            line_d = '0;
        end else if (we) begin
            for (int i = 0; i < BEATS; i++) begin
                if (idx == 4'(i)) begin
                    line_d[i*BEAT_BITS +: BEAT_BITS] = din;
                end
            end
        end
    end

    // The line register. clr is the bridge's synchronous reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign line = line_q;

endmodule

// File: rtl/mm_burst_bridge.sv
// Turns cache line fill/evict strobes into 8-beat Avalon-MM read/write bursts.
// Latency: command on the bus 1 cycle after the request; done/valid pulses 1 cycle after the last beat.
// Backpressure: av_waitrequest stalls commands and write beats; the cache waits on mm_busy.
module mm_burst_bridge
    import mm_burst_bridge_pkg::*;
#(
    parameter int LINE_BITS = DEF_LINE_BITS,
    parameter int BEAT_BITS = DEF_BEAT_BITS,
    parameter int BEATS     = DEF_BEATS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            mm_a,
    input  logic                   mm_read,
    input  logic                   mm_write,
    input  logic [LINE_BITS-1:0]   mm_wd,
    input  logic [LINE_BITS/8-1:0] mm_be,
    output logic [LINE_BITS-1:0]   mm_rd,
    output logic                   mm_readdata_valid,
    output logic                   mm_writedone,
    output logic                   mm_busy,
    output logic [31:0]            av_address,
    output logic [3:0]             av_burstcount,
    output logic                   av_read,
    output logic                   av_write,
    output logic [BEAT_BITS-1:0]   av_writedata,
    output logic [BEAT_BITS/8-1:0] av_byteenable,
    input  logic                   av_waitrequest,
    input  logic [BEAT_BITS-1:0]   av_readdata,
    input  logic                   av_readdatavalid
);

    localparam int BEAT_BE = BEAT_BITS / 8;
    localparam int LINE_BE = LINE_BITS / 8;
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 rd_pend_q, rd_pend_d;
    logic [LINE_BITS-1:0] wd_q, wd_d;
    logic [LINE_BE-1:0]   be_q, be_d;
    logic [31:0]          av_address_q, av_address_d;
    logic [3:0]           av_burstcount_q, av_burstcount_d;
    logic                 av_read_q, av_read_d;
    logic                 av_write_q, av_write_d;
    logic [BEAT_BITS-1:0] av_writedata_q, av_writedata_d;
    logic [BEAT_BE-1:0]   av_byteenable_q, av_byteenable_d;
    logic                 mm_readdata_valid_q, mm_readdata_valid_d;
    logic                 mm_writedone_q, mm_writedone_d;
    logic                 mm_busy_q, mm_busy_d;
    logic                 gather_we;

    // Next state: capture the request in IDLE, step the beat counter on accepted or valid beats.
    // A combined request runs the evict first so the fill sees memory after the write.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_pend_d    = rd_pend_q;
        wd_d         = wd_q;
        be_d         = be_q;
        av_address_d = av_address_q;
        gather_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mm_write) begin
                    wd_d         = mm_wd;
                    be_d         = mm_be;
                    av_address_d = line_align(mm_a);
                    cnt_d        = 4'd0;
                    rd_pend_d    = mm_read;
                    state_d      = ST_WR_BURST;
                end else if (mm_read) begin
                    av_address_d = line_align(mm_a);
                    state_d      = ST_RD_CMD;
                end
            end
            ST_WR_BURST: begin
                if (!av_waitrequest) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d     = 4'd0;
                        rd_pend_d = 1'b0;
                        state_d   = rd_pend_q ? ST_RD_CMD : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_RD_CMD: begin
                if (!av_waitrequest) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (av_readdatavalid) begin
                    gather_we = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = 4'd0;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered outputs follow the next state, so the bus sees a command the cycle after the request.
    always_comb begin
        av_write_d          = (state_d == ST_WR_BURST);
        av_read_d           = (state_d == ST_RD_CMD);
        mm_busy_d           = (state_d != ST_IDLE);
        mm_readdata_valid_d = (state_d == ST_RESP);
        mm_writedone_d      = (state_q == ST_WR_BURST) && !av_waitrequest && (cnt_q == LAST_BEAT);
        av_burstcount_d     = (av_write_d || av_read_d) ? 4'(BEATS) : 4'd0;
        av_writedata_d      = av_writedata_q;
        av_byteenable_d     = '1;
        if (state_d == ST_WR_BURST) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt_d == 4'(i)) begin
                    av_writedata_d  = wd_d[i*BEAT_BITS +: BEAT_BITS];
                    av_byteenable_d = be_d[i*BEAT_BE +: BEAT_BE];
                end
            end
        end
    end

    // State, capture and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q             <= ST_IDLE;
            cnt_q               <= 4'd0;
            rd_pend_q           <= 1'b0;
            wd_q                <= '0;
            be_q                <= '0;
            av_address_q        <= '0;
            av_burstcount_q     <= 4'd0;
            av_read_q           <= 1'b0;
            av_write_q          <= 1'b0;
            av_writedata_q      <= '0;
            av_byteenable_q     <= '0;
            mm_readdata_valid_q <= 1'b0;
            mm_writedone_q      <= 1'b0;
            mm_busy_q           <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            rd_pend_q           <= rd_pend_d;
            wd_q                <= wd_d;
            be_q                <= be_d;
            av_address_q        <= av_address_d;
            av_burstcount_q     <= av_burstcount_d;
            av_read_q           <= av_read_d;
            av_write_q          <= av_write_d;
            av_writedata_q      <= av_writedata_d;
            av_byteenable_q     <= av_byteenable_d;
            mm_readdata_valid_q <= mm_readdata_valid_d;
            mm_writedone_q      <= mm_writedone_d;
            mm_busy_q           <= mm_busy_d;
        end
    end

    // Fill line assembly; the bridge reset also clears the line.
    line_gather #(
        .LINE_BITS(LINE_BITS),
        .BEAT_BITS(BEAT_BITS),
        .BEATS    (BEATS)
    ) u_gather (
        .clk (clk),
        .clr (!reset),
        .we  (gather_we),
        .idx (cnt_q),
        .din (av_readdata),
        .line(mm_rd)
    );

    assign av_address        = av_address_q;
    assign av_burstcount     = av_burstcount_q;
    assign av_read           = av_read_q;
    assign av_write          = av_write_q;
    assign av_writedata      = av_writedata_q;
    assign av_byteenable     = av_byteenable_q;
    assign mm_readdata_valid = mm_readdata_valid_q;
    assign mm_writedone      = mm_writedone_q;
    assign mm_busy           = mm_busy_q;

endmodule

// File: tb/tb_mm_burst_bridge.sv
// Directed bench for mm_burst_bridge with a small Avalon slave model.
// Inputs change and outputs are sampled on the falling edge; cycle 0 is the request cycle.
// The slave stalls chosen write beats once and returns read beats with a configurable gap.
module tb_mm_burst_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  mm_a;
    logic         mm_read, mm_write;
    logic [255:0] mm_wd;
    logic [31:0]  mm_be;
    logic [255:0] mm_rd;
    logic         mm_readdata_valid, mm_writedone, mm_busy;
    logic [31:0]  av_address;
    logic [3:0]   av_burstcount;
    logic         av_read, av_write;
    logic [31:0]  av_writedata;
    logic [3:0]   av_byteenable;
    logic         av_waitrequest;
    logic [31:0]  av_readdata;
    logic         av_readdatavalid;

    int vectors = 0;
    int miscompares = 0;

    int          cyc, wb, rb, wd_cnt, wd_cyc, rv_cnt, rv_cyc, rd_cyc, end_cyc, hold_err;
    logic [31:0] first_addr;
    logic [3:0]  first_bc;
    logic [31:0] wdat_seen [8];
    logic [3:0]  wbe_seen  [8];
    logic [31:0] be_exp;

    always #5 clk = ~clk;

    mm_burst_bridge dut (
        .clk              (clk),
        .reset            (reset),
        .mm_a             (mm_a),
        .mm_read          (mm_read),
        .mm_write         (mm_write),
        .mm_wd            (mm_wd),
        .mm_be            (mm_be),
        .mm_rd            (mm_rd),
        .mm_readdata_valid(mm_readdata_valid),
        .mm_writedone     (mm_writedone),
        .mm_busy          (mm_busy),
        .av_address       (av_address),
        .av_burstcount    (av_burstcount),
        .av_read          (av_read),
        .av_write         (av_write),
        .av_writedata     (av_writedata),
        .av_byteenable    (av_byteenable),
        .av_waitrequest   (av_waitrequest),
        .av_readdata      (av_readdata),
        .av_readdatavalid (av_readdatavalid)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    // Slave model: runs from the cycle after the request until mm_busy drops or max_cyc expires.
    task automatic run_txn(input int max_cyc, input logic [7:0] stall_mask, input int rd_gap,
                           input logic [31:0] rbase, input logic spam);
        int   k;
        logic stalled, rd_acc;
        cyc = 0; wb = 0; rb = 0; wd_cnt = 0; wd_cyc = -1; rv_cnt = 0; rv_cyc = -1;
        rd_cyc = -1; end_cyc = -1; hold_err = 0; k = 0; stalled = 1'b0; rd_acc = 1'b0;
        while (end_cyc < 0) begin
            @(negedge clk);
            cyc++;
            mm_read = 1'b0; mm_write = 1'b0;
            av_waitrequest = 1'b0; av_readdatavalid = 1'b0; av_readdata = '0;
            if (cyc == 1) begin
                first_addr = av_address;
                first_bc   = av_burstcount;
            end
            if (mm_writedone) begin wd_cnt++; wd_cyc = cyc; end
            if (mm_readdata_valid) begin rv_cnt++; rv_cyc = cyc; end
            if (!mm_busy || cyc >= max_cyc) begin
                end_cyc = cyc;
            end else begin
                if ((av_write || av_read) && (av_address !== first_addr || av_burstcount !== 4'd8))
                    hold_err++;
                if (av_write) begin
                    if (wb < 8 && stall_mask[wb] && !stalled) begin
                        av_waitrequest = 1'b1;
                        stalled = 1'b1;
                    end else begin
                        if (wb < 8) begin
                            wdat_seen[wb] = av_writedata;
                            wbe_seen[wb]  = av_byteenable;
                        end
                        wb++;
                        stalled = 1'b0;
                    end
                end
                if (av_read) begin
                    if (rd_cyc < 0) rd_cyc = cyc;
                    rd_acc = 1'b1;
                    k = 0;
                end else if (rd_acc && rb < 8) begin
                    k++;
                    if (k >= 2 && (k - 2) % rd_gap == 0) begin
                        av_readdatavalid = 1'b1;
                        av_readdata = rbase + 32'(rb);
                        rb++;
                    end
                end
                if (spam) begin
                    mm_read = 1'b1; mm_write = 1'b1; mm_a = 32'hFFFF_FFE0;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0; mm_a = '0; mm_read = 1'b0; mm_write = 1'b0; mm_wd = '0; mm_be = '0;
        av_waitrequest = 1'b0; av_readdata = '0; av_readdatavalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", mm_busy, 0);
        chk("rst_av_read", av_read, 0);
        chk("rst_av_write", av_write, 0);
        chk("rst_burstcount", av_burstcount, 0);
        chk("rst_address", av_address, 0);
        chk("rst_mm_rd", mm_rd, 0);
        chk("rst_valid", mm_readdata_valid, 0);
        reset = 1'b1;
        @(negedge clk);

        // Plain read, no stalls.
        mm_a = 32'h0001_2345; mm_read = 1'b1;
        run_txn(40, 8'h00, 1, 32'hA0, 1'b0);
        chk("t1_address", first_addr, 32'h0001_2340);
        chk("t1_burstcount", first_bc, 4'd8);
        chk("t1_rd_cmd_cycle", rd_cyc, 1);
        chk("t1_valid_cycle", rv_cyc, 11);
        chk("t1_valid_pulses", rv_cnt, 1);
        chk("t1_busy_fall", end_cyc, 12);
        chk("t1_beat0", mm_rd[31:0], 32'hA0);
        chk("t1_beat7", mm_rd[255:224], 32'hA7);
        chk("t1_line", mm_rd, mk_line(32'hA0));
        chk("t1_hold", hold_err, 0);

        // Write with stalls on beats 0 and 3.
        @(negedge clk);
        mm_a = 32'h8000_001F; mm_wd = mk_line(32'h10); mm_be = 32'h0F0F_FFFF; mm_write = 1'b1;
        be_exp = 32'h0F0F_FFFF;
        run_txn(40, 8'b0000_1001, 1, 32'h0, 1'b0);
        chk("t2_address", first_addr, 32'h8000_0000);
        chk("t2_beats", wb, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_data%0d", i), wdat_seen[i], 32'h10 + 32'(i));
            chk($sformatf("t2_be%0d", i), wbe_seen[i], be_exp[i*4 +: 4]);
        end
        chk("t2_be6_full", wbe_seen[6], 4'hF);
        chk("t2_be7_none", wbe_seen[7], 4'h0);
        chk("t2_done_cycle", wd_cyc, 11);
        chk("t2_done_pulses", wd_cnt, 1);
        chk("t2_busy_fall", end_cyc, 11);
        chk("t2_hold", hold_err, 0);

        // Combined read+write: evict first, then fill with no idle gap.
        @(negedge clk);
        mm_a = 32'h0000_ABCD; mm_wd = mk_line(32'h20); mm_be = '1; mm_write = 1'b1; mm_read = 1'b1;
        run_txn(60, 8'h00, 1, 32'hB0, 1'b0);
        chk("t3_beats", wb, 8);
        chk("t3_last_data", wdat_seen[7], 32'h27);
        chk("t3_done_cycle", wd_cyc, 9);
        chk("t3_rd_cmd_cycle", rd_cyc, 9);
        chk("t3_done_pulses", wd_cnt, 1);
        chk("t3_valid_pulses", rv_cnt, 1);
        chk("t3_valid_cycle", rv_cyc, 19);
        chk("t3_line", mm_rd, mk_line(32'hB0));
        chk("t3_hold", hold_err, 0);

        // Gapped read data while the cache keeps requesting during busy.
        @(negedge clk);
        mm_a = 32'h0000_777F; mm_read = 1'b1;
        run_txn(80, 8'h00, 3, 32'h3000_0000, 1'b1);
        chk("t4_address", first_addr, 32'h0000_7760);
        chk("t4_valid_cycle", rv_cyc, 25);
        chk("t4_valid_pulses", rv_cnt, 1);
        chk("t4_no_writes", wb, 0);
        chk("t4_no_done", wd_cnt, 0);
        chk("t4_busy_fall", end_cyc, 26);
        chk("t4_line", mm_rd, mk_line(32'h3000_0000));

        // Reset in the middle of a fill after four beats.
        @(negedge clk);
        mm_a = 32'h0000_4447; mm_read = 1'b1;
        @(negedge clk);
        mm_read = 1'b0;
        chk("t5_rd_cmd", av_read, 1);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            av_readdatavalid = 1'b1; av_readdata = 32'hC0 + 32'(i);
        end
        @(negedge clk);
        av_readdatavalid = 1'b0;
        chk("t5_partial", mm_rd[127:0], {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        chk("t5_busy_pre", mm_busy, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_av_read", av_read, 0);
        chk("t5_av_write", av_write, 0);
        chk("t5_busy", mm_busy, 0);
        chk("t5_valid", mm_readdata_valid, 0);
        chk("t5_done", mm_writedone, 0);
        chk("t5_burstcount", av_burstcount, 0);
        chk("t5_address", av_address, 0);
        chk("t5_mm_rd", mm_rd, 0);
        reset = 1'b1; av_readdatavalid = 1'b1; av_readdata = 32'hDEAD_0000;
        @(negedge clk);
        av_readdata = 32'hDEAD_0001;
        @(negedge clk);
        av_readdatavalid = 1'b0; av_readdata = '0;
        chk("t5_stray_line", mm_rd, 0);
        chk("t5_stray_busy", mm_busy, 0);
        mm_a = 32'h0000_5550; mm_read = 1'b1;
        run_txn(40, 8'h00, 1, 32'hE0, 1'b0);
        chk("t5_new_valid", rv_cnt, 1);
        chk("t5_new_line", mm_rd, mk_line(32'hE0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
